// File: rtl/lut_breadboard_pkg.sv
// lut_breadboard shared types and defaults.
// FSM encoding and build-time constants.
package lut_breadboard_pkg;

  localparam int N_IN_DEF  = 4;
  localparam int N_OUT_DEF = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lut_breadboard_if.sv
// Sweep-row result stream of lut_breadboard.
// Valid/ready handshake with row index and function values.
interface lut_breadboard_if #(
  parameter int N_IN  = lut_breadboard_pkg::N_IN_DEF,
  parameter int N_OUT = lut_breadboard_pkg::N_OUT_DEF
);

  logic             out_valid;
  logic             out_ready;
  logic [N_IN-1:0]  out_row;
  logic [N_OUT-1:0] out_f;

  modport master (
    output out_valid,
    output out_row,
    output out_f,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_row,
    input  out_f,
    output out_ready
  );

endinterface

// File: rtl/lut_breadboard_channel.sv
// lut_channel: one programmable truth table with
// registered direct read, sweep read and popcount.
module lut_channel
  import lut_breadboard_pkg::*;
#(
  parameter  int N_IN = N_IN_DEF,
  localparam int ROWS = 2 ** N_IN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [ROWS-1:0] wdata_i,
  input  logic [N_IN-1:0] in_vec_i,
  input  logic [N_IN-1:0] row_i,
  input  logic            acc_clr_i,
  input  logic            acc_en_i,
  input  logic            cnt_ld_i,
  output logic            eval_o,
  output logic            sweep_o,
  output logic [N_IN:0]   cnt_o
);

  logic [ROWS-1:0] lut_q, lut_d;
  logic [N_IN:0]   acc_q, acc_d;
  logic [N_IN:0]   cnt_q, cnt_d;
  logic            eval_q;

  assign sweep_o = lut_q[row_i];
  assign eval_o  = eval_q;
  assign cnt_o   = cnt_q;

  always_comb begin
    lut_d = lut_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (we_i)
      lut_d = wdata_i;
    if (acc_clr_i)
      acc_d = '0;
    else if (acc_en_i)
      acc_d = acc_q + {{N_IN{1'b0}}, sweep_o};
    if (cnt_ld_i)
      cnt_d = acc_q;
  end

  // eval reads lut_q, so a same-cycle write returns the old table
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_q  <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      eval_q <= 1'b0;
    end else begin
      lut_q  <= lut_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      eval_q <= lut_q[in_vec_i];
    end
  end

endmodule

// File: rtl/lut_breadboard.sv
// lut_breadboard: N_OUT programmable boolean functions
// with direct evaluation and a handshaked full-table sweep.
module lut_breadboard
  import lut_breadboard_pkg::*;
#(
  parameter  int N_IN  = N_IN_DEF,
  parameter  int N_OUT = N_OUT_DEF,
  localparam int ROWS  = 2 ** N_IN,
  localparam int CH_W  = ch_w(N_OUT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [ROWS-1:0]          cfg_data,
  input  logic [N_IN-1:0]          in_vec,
  output logic [N_OUT-1:0]         eval_f,
  input  logic                     start,
  input  logic                     abort,
  lut_breadboard_if.master         bus,
  output logic                     busy,
  output logic                     done,
  output logic [N_OUT*(N_IN+1)-1:0] ones_cnt
);

  state_e          state_q, state_d;
  logic [N_IN-1:0] row_q, row_d;
  logic            run;
  logic            acc_clr;
  logic            acc_en;
  logic            cnt_ld;
  logic [N_OUT-1:0] sweep_f;

  assign run           = (state_q == S_RUN);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign bus.out_valid = run;
  assign bus.out_row   = run ? row_q : '0;
  assign bus.out_f     = run ? sweep_f : '0;

  // abort wins over both start and a same-cycle transfer
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    cnt_ld  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_RUN;
          row_d   = '0;
          acc_clr = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          row_d   = '0;
        end else if (bus.out_ready) begin
          acc_en = 1'b1;
          row_d  = row_q + N_IN'(1);
          if (&row_q)
            state_d = S_DONE;
        end
      end
      S_DONE: begin
        cnt_ld  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_ch
    lut_channel #(.N_IN(N_IN)) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (cfg_we && !busy && (cfg_ch == CH_W'(k))),
      .wdata_i   (cfg_data),
      .in_vec_i  (in_vec),
      .row_i     (row_q),
      .acc_clr_i (acc_clr),
      .acc_en_i  (acc_en),
      .cnt_ld_i  (cnt_ld),
      .eval_o    (eval_f[k]),
      .sweep_o   (sweep_f[k]),
      .cnt_o     (ones_cnt[k*(N_IN+1) +: N_IN+1])
    );
  end

endmodule

// File: doc/lut_breadboard.md
LUT_BREADBOARD -- requirements
Module: lut_breadboard

Interface
REQ-001 Parameter N_IN, default 4: number of boolean inputs; rows = 2**N_IN; legal range 2..8.
REQ-002 Parameter N_OUT, default 3: number of independently programmable output functions; legal range 1..8.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port cfg_we, input, 1: truth-table write strobe.
REQ-007 Port cfg_ch, input, clog2(N_OUT) (min 1): channel to write.
REQ-008 Port cfg_data, input, 2**N_IN: truth table; bit i = output for input row i.
REQ-009 Port in_vec, input, N_IN: direct-evaluation input; MSB = first variable.
REQ-010 Port eval_f, output, N_OUT: registered direct evaluation of in_vec.
REQ-011 Port start, input, 1: begin sweep of all rows.
REQ-012 Port abort, input, 1: cancel sweep.
REQ-013 Port out_valid, output, 1; out_ready, input, 1: sweep-row handshake.
REQ-014 Port out_row, output, N_IN: row index of presented result.
REQ-015 Port out_f, output, N_OUT: function values for out_row.
REQ-016 Port busy, output, 1: sweep in progress.
REQ-017 Port done, output, 1: one-cycle pulse after final row accepted.
REQ-018 Port ones_cnt, output, N_OUT*(N_IN+1): per-channel count of true rows from the last completed sweep; channel k in slice k.

Function
REQ-019 Write: cfg_we=1 in IDLE loads cfg_data into LUT[cfg_ch] at the clock edge; cfg_ch >= N_OUT ignored.
REQ-020 cfg_we while busy ignored; LUTs frozen during a sweep.
REQ-021 eval_f[k] = LUT[k][in_vec], registered, latency 1 cycle, updated every cycle in all states; a write and a read of the same channel in one cycle returns the old LUT.
REQ-022 FSM states IDLE, RUN, DONE.
REQ-023 IDLE -> RUN on start=1 (abort=0): row counter=0, accumulators cleared; out_valid=1 the next cycle.
REQ-024 RUN: out_valid=1, out_row=row, out_f[k]=LUT[k][row]; transfer when out_valid&&out_ready.
REQ-025 While out_valid=1 and out_ready=0, out_row and out_f held stable.
REQ-026 On transfer, accumulator[k] += out_f[k]; row increments; on transfer of row 2**N_IN-1 go to DONE (no wrap to 0 re-presented).
REQ-027 Accumulator width N_IN+1; all-ones LUT yields exactly 2**N_IN without overflow.
REQ-028 DONE lasts one cycle: done=1, ones_cnt updated from accumulators, then IDLE.
REQ-029 abort=1 in RUN -> IDLE next cycle, out_valid=0, no done, ones_cnt unchanged; abort has priority over a same-cycle transfer and over start.
REQ-030 start in RUN or DONE ignored.
REQ-031 busy=1 in RUN and DONE, else 0.

Reset
REQ-032 rst_n=0 asynchronously forces IDLE, all LUTs=0, row=0, accumulators=0, ones_cnt=0, eval_f=0, out_valid=0, out_row=0, out_f=0, done=0, busy=0; applies mid-sweep with no done.

Structure
REQ-033 Package lut_breadboard_pkg holds the state enum and default N_IN/N_OUT constants.
REQ-034 Sub-module lut_channel (one LUT register, direct-eval read, sweep read, popcount accumulator), instantiated N_OUT times; FSM and row counter in top level.

Verification
REQ-035 Defaults; program ch0=0xF2F2, ch1=0xF2F2, ch2=0x8001; sweep with out_ready=1 -> 16 transfers rows 0..15, done once, ones_cnt = {2,10,10}.
REQ-036 in_vec=4'b0101 after programming above -> eval_f=3'b011 one cycle later; in_vec=4'b1111 -> 3'b111.
REQ-037 Sweep with out_ready toggled pseudo-randomly -> out_row/out_f stable during stalls, no row skipped or repeated, same ones_cnt as REQ-035.
REQ-038 abort asserted at row 7 -> out_valid=0 next cycle, no done, ones_cnt retains previous value; cfg_we mid-sweep leaves LUT unchanged.
REQ-039 rst_n pulsed low asynchronously at row 9 -> all outputs 0 immediately, subsequent sweep returns ones_cnt = 0.
REQ-040 LUT all-ones (0xFFFF) on all channels -> ones_cnt each = 16; N_IN=2 build -> 4 transfers, counts 0..4 correct.
